softmax_buffer_server: RTL and testbench
========================================

Name: softmax_buffer_server

Overview:
- Memory-side counterpart of the softmax engine.
- Accepts an input vector stream and stores it in an on-chip register-file buffer, then serves the engine's three read ports (`addr`, `sub0_inp_addr`, `sub1_inp_addr`) with same-cycle data.
- Sequences `init`/`start` to the engine, waits for `done`, captures result vectors into a result bank, and streams them out.
- Sits between the system streaming fabric and one softmax instance.

Parameters:
- DATAWIDTH, 16, bits per element.
- NUM, 8, elements per vector word.
- ADDRSIZE, 8, engine address width.
- DEPTH, 64, vector words per bank (input bank and result bank each); DEPTH <= 2**ADDRSIZE.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  input beat valid.
- load_ready  out  1  buffer accepts beat.
- load_data  in  DATAWIDTH*NUM  input vector word.
- load_last  in  1  final beat of the vector set.
- addr  in  ADDRSIZE  engine max-stage read address.
- sub0_inp_addr  in  ADDRSIZE  engine stage-1 subtract read address.
- sub1_inp_addr  in  ADDRSIZE  engine pre-sub read address.
- inp  out  DATAWIDTH*NUM  data at addr.
- sub0_inp  out  DATAWIDTH*NUM  data at sub0_inp_addr.
- sub1_inp  out  DATAWIDTH*NUM  data at sub1_inp_addr.
- start_addr  out  ADDRSIZE  constant 0.
- end_addr  out  ADDRSIZE  loaded word count n.
- init  out  1  one-cycle pulse; engine latches start_addr.
- start  out  1  one-cycle pulse; engine begins.
- done  in  1  engine done level.
- res_valid  in  1  result word valid this cycle.
- res_data  in  DATAWIDTH*NUM  result word.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATAWIDTH*NUM  result word.
- out_last  out  1  final result beat.
- busy  out  1  high whenever state != IDLE.
- err_overflow  out  1  sticky: load or result beat dropped because its bank was full.
- err_short  out  1  sticky: done fell with fewer than n results captured.

Behaviour:
- Reset (reset=0, async): state=IDLE; load count, result count and drain pointer = 0; end_addr=0; all sticky flags=0; init=start=out_valid=out_last=0; load_ready=1 after reset release. Bank contents are not reset.
- Read ports:
  - Combinational (zero latency): inp=in_bank[addr], likewise for sub0/sub1.
  - Out-of-range address (>= DEPTH) returns 0.
  - The engine registers data in the same cycle it presents the address; this timing is mandatory.
- States: IDLE -> INIT -> START -> RUN -> DRAIN -> IDLE.
- IDLE:
  - load_ready=1.
  - On load_valid: write in_bank[cnt], then cnt++.
  - If cnt==DEPTH, drop the beat and set err_overflow.
  - On an accepted or dropped beat with load_last: latch end_addr=cnt_after (saturated at DEPTH) and go to INIT.
- INIT: init=1 for exactly one cycle -> START.
- START: start=1 for exactly one cycle; clear the result count -> RUN.
- RUN:
  - load_ready=0.
  - Each res_valid writes res_bank[rcnt], then rcnt++. If rcnt==DEPTH, drop and set err_overflow.
  - Track done_d (done delayed 1 cycle). Falling edge (done_d=1, done=0) -> DRAIN.
  - On that edge, set err_short if rcnt < end_addr (rcnt includes a res_valid arriving that same cycle).
  - done never rising keeps RUN indefinitely; there is no timeout.
- DRAIN:
  - out_valid=1 while ptr<rcnt; out_data=res_bank[ptr] (combinational); out_last=(ptr==rcnt-1).
  - out_valid&out_ready -> ptr++. After the last handshake, go to IDLE and clear cnt and ptr.
  - If rcnt==0, go to IDLE next cycle with no beats.
  - out_data must stay stable while out_valid&~out_ready.
- res_valid outside RUN is ignored. load_valid outside IDLE is not accepted (ready=0).
- Reset mid-operation aborts immediately. The engine is not notified; integration resets both together.
- Width rules: counters are ADDRSIZE+1 bits internally; end_addr is truncated to ADDRSIZE.

Decomposition:
- Shared package/defines: DATAWIDTH, NUM, ADDRSIZE, DEPTH, and state encodings (IDLE=0, INIT=1, START=2, RUN=3, DRAIN=4).
- One natural sub-module: softmax_vec_regfile — DEPTH x DATAWIDTH*NUM storage, one write port, parameterised number of combinational read ports. Instantiate it for in_bank (3 read ports) and res_bank (1 read port).

Test Plan:
- Load 4 beats (words 0x11..,0x22..,0x33..,0x44..), last on beat 4 -> end_addr=4, start_addr=0; init pulses exactly 1 cycle, start exactly 1 cycle later; busy=1.
- In RUN, drive addr=2, sub0=0, sub1=3 in the same cycle -> inp=0x33.., sub0_inp=0x11.., sub1_inp=0x44..; addr=70 -> inp=0.
- Inject 4 res_valid words R0..R3, then done 1->0 -> DRAIN emits R0..R3 in order, out_last only on R3, err_short=0.
- Hold out_ready=0 for 5 cycles mid-drain -> out_data stable, no beat skipped or duplicated.
- Load 65 beats with DEPTH=64 -> 64 stored, end_addr=64, err_overflow=1.
- Done falls after only 2 results -> err_short=1, exactly 2 beats drained.
- Assert reset=0 asynchronously mid-RUN -> outputs immediately at reset values, state IDLE; a new 1-beat load completes normally.

Source files
------------

// File: rtl/softmax_buffer_server_pkg.sv
// Shared sizing and state encoding for the softmax buffer server and its storage.
package softmax_buffer_server_pkg;

  localparam int unsigned DATAWIDTH = 16;
  localparam int unsigned NUM       = 8;
  localparam int unsigned ADDRSIZE  = 8;
  localparam int unsigned DEPTH     = 64;

  localparam int unsigned WORD_W = DATAWIDTH * NUM;
  localparam int unsigned CNT_W  = ADDRSIZE + 1;
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/softmax_buffer_server_if.sv
// Load stream, engine read/control ports and result stream of the buffer server.
interface softmax_buffer_server_if;
  import softmax_buffer_server_pkg::*;

  logic                load_valid;
  logic                load_ready;
  word_t               load_data;
  logic                load_last;
  logic [ADDRSIZE-1:0] addr;
  logic [ADDRSIZE-1:0] sub0_inp_addr;
  logic [ADDRSIZE-1:0] sub1_inp_addr;
  word_t               inp;
  word_t               sub0_inp;
  word_t               sub1_inp;
  logic [ADDRSIZE-1:0] start_addr;
  logic [ADDRSIZE-1:0] end_addr;
  logic                init;
  logic                start;
  logic                done;
  logic                res_valid;
  word_t               res_data;
  logic                out_valid;
  logic                out_ready;
  word_t               out_data;
  logic                out_last;
  logic                busy;
  logic                err_overflow;
  logic                err_short;

  modport slave (
    input  load_valid, load_data, load_last, addr, sub0_inp_addr, sub1_inp_addr,
           done, res_valid, res_data, out_ready,
    output load_ready, inp, sub0_inp, sub1_inp, start_addr, end_addr, init, start,
           out_valid, out_data, out_last, busy, err_overflow, err_short
  );

  modport master (
    output load_valid, load_data, load_last, addr, sub0_inp_addr, sub1_inp_addr,
           done, res_valid, res_data, out_ready,
    input  load_ready, inp, sub0_inp, sub1_inp, start_addr, end_addr, init, start,
           out_valid, out_data, out_last, busy, err_overflow, err_short
  );

endinterface

// File: rtl/softmax_vec_regfile.sv
// DEPTH x word register file: one synchronous write port, NRD zero-latency read ports.
module softmax_vec_regfile
  import softmax_buffer_server_pkg::*;
#(
  parameter int unsigned NRD = 1
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [IDX_W-1:0]             waddr,
  input  word_t                        wdata,
  input  logic [NRD-1:0][ADDRSIZE-1:0] raddr,
  output logic [NRD-1:0][WORD_W-1:0]   rdata
);

  word_t mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Addresses beyond the bank read as zero.
  always_comb begin
    for (int i = 0; i < int'(NRD); i++) begin
      if ({1'b0, raddr[i]} >= CNT_W'(DEPTH)) begin
        rdata[i] = '0;
      end else begin
        rdata[i] = mem[raddr[i][IDX_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/softmax_buffer_server.sv
// Buffers an input vector set, sequences one softmax run, captures and streams its results.
module softmax_buffer_server
  import softmax_buffer_server_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  softmax_buffer_server_if.slave  bus
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    rcnt_q, rcnt_d;
  logic [CNT_W-1:0]    ptr_q, ptr_d;
  logic [ADDRSIZE-1:0] end_addr_q, end_addr_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_short_q, err_short_d;
  logic                done_q, done_d;
  logic                init_q, init_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                load_ready_q, load_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;

  logic                         in_we;
  logic                         res_we;
  logic [2:0][WORD_W-1:0]       in_rd;
  logic [0:0][WORD_W-1:0]       res_rd;

  softmax_vec_regfile #(.NRD(3)) u_in_bank (
    .clk   (clk),
    .we    (in_we),
    .waddr (cnt_q[IDX_W-1:0]),
    .wdata (bus.load_data),
    .raddr ({bus.sub1_inp_addr, bus.sub0_inp_addr, bus.addr}),
    .rdata (in_rd)
  );

  softmax_vec_regfile #(.NRD(1)) u_res_bank (
    .clk   (clk),
    .we    (res_we),
    .waddr (rcnt_q[IDX_W-1:0]),
    .wdata (bus.res_data),
    .raddr (ADDRSIZE'(ptr_q)),
    .rdata (res_rd)
  );

  // Next-state, counters, and registered outputs derived from the next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    ptr_d       = ptr_q;
    end_addr_d  = end_addr_q;
    err_ovf_d   = err_ovf_q;
    err_short_d = err_short_q;
    done_d      = bus.done;
    in_we       = 1'b0;
    res_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.load_valid) begin
          if (cnt_q < CNT_W'(DEPTH)) begin
            in_we = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            err_ovf_d = 1'b1;
          end
          if (bus.load_last) begin
            end_addr_d = ADDRSIZE'(cnt_d);
            state_d    = ST_INIT;
          end
        end
      end
      ST_INIT: state_d = ST_START;
      ST_START: begin
        rcnt_d  = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.res_valid) begin
          if (rcnt_q < CNT_W'(DEPTH)) begin
            res_we = 1'b1;
            rcnt_d = rcnt_q + CNT_W'(1);
          end else begin
            err_ovf_d = 1'b1;
          end
        end
        // Falling edge of done ends the run; the count includes this cycle's result.
        if (done_q && !bus.done) begin
          state_d = ST_DRAIN;
          ptr_d   = '0;
          if (rcnt_d < CNT_W'(end_addr_q)) begin
            err_short_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (rcnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ptr_d   = '0;
        end else if (out_valid_q && bus.out_ready) begin
          if (ptr_q == rcnt_q - CNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    init_d       = (state_d == ST_INIT);
    start_d      = (state_d == ST_START);
    busy_d       = (state_d != ST_IDLE);
    load_ready_d = (state_d == ST_IDLE);
    out_valid_d  = (state_d == ST_DRAIN) && (ptr_d < rcnt_d);
    out_last_d   = out_valid_d && (ptr_d == rcnt_d - CNT_W'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rcnt_q       <= '0;
      ptr_q        <= '0;
      end_addr_q   <= '0;
      err_ovf_q    <= 1'b0;
      err_short_q  <= 1'b0;
      done_q       <= 1'b0;
      init_q       <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rcnt_q       <= rcnt_d;
      ptr_q        <= ptr_d;
      end_addr_q   <= end_addr_d;
      err_ovf_q    <= err_ovf_d;
      err_short_q  <= err_short_d;
      done_q       <= done_d;
      init_q       <= init_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
    end
  end

  assign bus.inp          = in_rd[0];
  assign bus.sub0_inp     = in_rd[1];
  assign bus.sub1_inp     = in_rd[2];
  assign bus.out_data     = res_rd[0];
  assign bus.start_addr   = '0;
  assign bus.end_addr     = end_addr_q;
  assign bus.init         = init_q;
  assign bus.start        = start_q;
  assign bus.busy         = busy_q;
  assign bus.load_ready   = load_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_last     = out_last_q;
  assign bus.err_overflow = err_ovf_q;
  assign bus.err_short    = err_short_q;

endmodule

// File: tb/tb_softmax_buffer_server.sv
// Randomized scoreboard bench for softmax_buffer_server against a simple array/queue model.
module tb_softmax_buffer_server;
  import softmax_buffer_server_pkg::*;

  typedef struct packed {
    word_t d;
    logic  l;
  } beat_t;

  logic clk;
  logic reset;
  softmax_buffer_server_if bus ();

  softmax_buffer_server dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q [$];
  word_t in_model [DEPTH];
  int    n_loaded = 0;
  int    exp_end = 0;
  bit    exp_ovf = 0;
  bit    exp_short = 0;

  task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic word_t rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic word_t model_rd(input logic [ADDRSIZE-1:0] a);
    if (int'(a) >= int'(DEPTH)) return '0;
    return in_model[a];
  endfunction

  function automatic logic [ADDRSIZE-1:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return ADDRSIZE'($urandom_range(DEPTH, 255));
    return ADDRSIZE'($urandom_range(0, n_loaded - 1));
  endfunction

  // Result-side monitor: pops expected beats on each handshake, checks stall stability.
  initial begin
    bit    stalled;
    beat_t held;
    beat_t e;
    stalled = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stalled = 0;
      end else if (bus.out_valid) begin
        if (stalled) begin
          chk("stall_data", bus.out_data, held.d);
          chk("stall_last", WORD_W'(bus.out_last), WORD_W'(held.l));
        end
        if (bus.out_ready) begin
          stalled = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat actual=%h required=none", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", bus.out_data, e.d);
            chk("out_last", WORD_W'(bus.out_last), WORD_W'(e.l));
          end
        end else begin
          stalled = 1;
          held = {bus.out_data, bus.out_last};
        end
      end else if (stalled) begin
        checks++;
        errors++;
        $display("FAIL valid_dropped actual=0 required=1");
        stalled = 0;
      end
    end
  end

  task automatic do_load(input int n, input bit pat);
    word_t w;
    logic [DATAWIDTH-1:0] e;
    n_loaded = 0;
    @(posedge clk); #1;
    chk("load_ready_idle", WORD_W'(bus.load_ready), WORD_W'(1));
    for (int i = 0; i < n; i++) begin
      if (pat) begin
        e = DATAWIDTH'(16'h1111 * (i + 1));
        w = {NUM{e}};
      end else begin
        w = rnd_word();
      end
      bus.load_valid = 1'b1;
      bus.load_data  = w;
      bus.load_last  = (i == n - 1);
      if (n_loaded < int'(DEPTH)) begin
        in_model[n_loaded] = w;
        n_loaded++;
      end else begin
        exp_ovf = 1;
      end
      @(posedge clk); #1;
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    exp_end = n_loaded;
  endtask

  task automatic check_pulses();
    logic [3:0] iv;
    logic [3:0] sv;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      iv[k] = bus.init;
      sv[k] = bus.start;
    end
    chk("init_pulse", WORD_W'(iv), WORD_W'(4'b0001));
    chk("start_pulse", WORD_W'(sv), WORD_W'(4'b0010));
    chk("end_addr", WORD_W'(bus.end_addr), WORD_W'(exp_end));
    chk("start_addr", WORD_W'(bus.start_addr), '0);
    chk("busy_run", WORD_W'(bus.busy), WORD_W'(1));
    chk("load_ready_run", WORD_W'(bus.load_ready), '0);
  endtask

  task automatic rd_ports(input logic [ADDRSIZE-1:0] a, input logic [ADDRSIZE-1:0] b,
                          input logic [ADDRSIZE-1:0] c);
    @(posedge clk); #1;
    bus.addr = a;
    bus.sub0_inp_addr = b;
    bus.sub1_inp_addr = c;
    @(negedge clk);
    chk("inp", bus.inp, model_rd(a));
    chk("sub0_inp", bus.sub0_inp, model_rd(b));
    chk("sub1_inp", bus.sub1_inp, model_rd(c));
  endtask

  task automatic run_results(input int k);
    word_t got [$];
    word_t w;
    @(posedge clk); #1;
    bus.done = 1'b1;
    for (int i = 0; i < k; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        bus.res_valid = 1'b0;
        @(posedge clk); #1;
      end
      w = rnd_word();
      bus.res_valid = 1'b1;
      bus.res_data  = w;
      if (got.size() < int'(DEPTH)) got.push_back(w);
      else exp_ovf = 1;
      @(posedge clk); #1;
    end
    bus.res_valid = 1'b0;
    bus.done = 1'b0;
    for (int j = 0; j < got.size(); j++) exp_q.push_back({got[j], 1'(j == got.size() - 1)});
    if (got.size() < exp_end) exp_short = 1;
  endtask

  task automatic drain(input int hold_at);
    bit finished;
    finished = 0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(posedge clk); #1;
      if (hold_at >= 0 && cyc >= hold_at && cyc < hold_at + 5) bus.out_ready = 1'b0;
      else bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (!bus.busy) finished = 1;
    end
    chk("drain_finished", WORD_W'(finished), WORD_W'(1));
    chk("beats_missing", WORD_W'(exp_q.size()), '0);
    chk("err_overflow", WORD_W'(bus.err_overflow), WORD_W'(exp_ovf));
    chk("err_short", WORD_W'(bus.err_short), WORD_W'(exp_short));
    chk("load_ready_back", WORD_W'(bus.load_ready), WORD_W'(1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, WORD_W'(bus.busy), '0);
    chk({tag, "_init"}, WORD_W'(bus.init), '0);
    chk({tag, "_start"}, WORD_W'(bus.start), '0);
    chk({tag, "_out_valid"}, WORD_W'(bus.out_valid), '0);
    chk({tag, "_out_last"}, WORD_W'(bus.out_last), '0);
    chk({tag, "_end_addr"}, WORD_W'(bus.end_addr), '0);
    chk({tag, "_err_ovf"}, WORD_W'(bus.err_overflow), '0);
    chk({tag, "_err_short"}, WORD_W'(bus.err_short), '0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data = '0;
    bus.load_last = 1'b0;
    bus.addr = '0;
    bus.sub0_inp_addr = '0;
    bus.sub1_inp_addr = '0;
    bus.done = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);
    chk("load_ready_rst", WORD_W'(bus.load_ready), WORD_W'(1));

    // Directed 4-word load, read ports, 4 results with a mid-drain stall.
    do_load(4, 1);
    check_pulses();
    rd_ports(8'd2, 8'd0, 8'd3);
    chk("inp_word2", bus.inp, {NUM{16'h3333}});
    rd_ports(8'd70, 8'd1, 8'd2);
    for (int i = 0; i < 6; i++) rd_ports(pick_addr(), pick_addr(), pick_addr());
    run_results(4);
    drain(1);

    // Random-size set with random read traffic.
    n = $urandom_range(5, 20);
    do_load(n, 0);
    check_pulses();
    for (int i = 0; i < 6; i++) rd_ports(pick_addr(), pick_addr(), pick_addr());
    run_results(n);
    drain(3);

    // Overflow on both banks.
    do_load(65, 0);
    check_pulses();
    chk("err_ovf_load", WORD_W'(bus.err_overflow), WORD_W'(1));
    rd_ports(8'd63, 8'd0, 8'd64);
    for (int i = 0; i < 4; i++) rd_ports(pick_addr(), pick_addr(), pick_addr());
    run_results(66);
    drain(-1);

    // Short result set.
    do_load(3, 0);
    check_pulses();
    run_results(2);
    drain(0);

    // Asynchronous reset in the middle of a run.
    do_load(2, 0);
    check_pulses();
    @(posedge clk); #1;
    bus.done = 1'b1;
    bus.res_valid = 1'b1;
    bus.res_data = rnd_word();
    @(posedge clk); #1;
    bus.res_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("midrun");
    bus.done = 1'b0;
    exp_q.delete();
    exp_ovf = 0;
    exp_short = 0;
    exp_end = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    do_load(1, 0);
    check_pulses();
    rd_ports(8'd0, 8'd0, 8'd0);
    run_results(1);
    drain(-1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
